bcd_add_seq: RTL and testbench

BCD_ADD_SEQ -- requirements
Module: bcd_add_seq

---
 rtl/bcd_add_seq.sv | 141 ++++++++++++++
 tb/tb_bcd_add_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_add_seq.sv
// Sequential packed-BCD adder: one decimal digit per clock, LSD first, with an IDLE/ADD/DONE handshake.
// Optional macro BCD_INPUT_CHECK_EN adds an err output flagging non-BCD operand digits.
module bcd_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  done
`ifdef BCD_INPUT_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               ready_r;
    logic               done_r;
    logic               cout_r;

    logic [3:0]         dig_a_s;
    logic [3:0]         dig_b_s;
    logic [4:0]         dsum_s;
    logic [3:0]         res_s;
    logic               carry_next_s;
    logic               last_s;
    logic [W-1:0]       mask_s;
    logic [W-1:0]       sum_next_s;
`ifdef BCD_INPUT_CHECK_EN
    logic               bad_s;
    logic               err_r;
`endif

    // Current digit: decimal-corrected sum, carry and merged sum word
    always_comb begin
        dig_a_s = a_r[{idx_r, 2'b00} +: 4];
        dig_b_s = b_r[{idx_r, 2'b00} +: 4];
        dsum_s  = {1'b0, dig_a_s} + {1'b0, dig_b_s} + {4'b0000, carry_r};
        if (dsum_s > 5'd9) begin
            // (s + 6) mod 16 only depends on the low nibble of s
            res_s        = dsum_s[3:0] + 4'd6;
            carry_next_s = 1'b1;
        end else begin
            res_s        = dsum_s[3:0];
            carry_next_s = 1'b0;
        end
        mask_s     = W'(4'hF) << {idx_r, 2'b00};
        sum_next_s = (sum_r & ~mask_s) | (W'(res_s) << {idx_r, 2'b00});
        last_s     = (idx_r == IDX_W'(DIGITS - 1));
`ifdef BCD_INPUT_CHECK_EN
        bad_s      = (dig_a_s > 4'd9) || (dig_b_s > 4'd9);
`endif
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= '0;
                        ready_r <= 1'b0;
                        state_r <= ADD;
`ifdef BCD_INPUT_CHECK_EN
                        err_r   <= 1'b0;
`endif
                    end
                end
                ADD: begin
                    sum_r   <= sum_next_s;
                    carry_r <= carry_next_s;
`ifdef BCD_INPUT_CHECK_EN
                    err_r   <= err_r | bad_s;
`endif
                    if (last_s) begin
                        cout_r  <= carry_next_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign done  = done_r;
`ifdef BCD_INPUT_CHECK_EN
    assign err   = err_r;
`endif

endmodule

// File: tb/tb_bcd_add_seq.sv
// Self-checking bench for bcd_add_seq: transaction-level decimal model, per-cycle compare, directed and random stimulus.
module tb_bcd_add_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          done;
`ifdef BCD_INPUT_CHECK_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bcd_add_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .sum   (sum),
        .cout  (cout),
        .done  (done)
`ifdef BCD_INPUT_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
        bit bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Reference: plain decimal arithmetic for valid BCD, digit rule otherwise; returns {cout, sum}
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        longint unsigned xv, yv, t, lim;
        logic [W-1:0] s;
        logic         c;
        int           ds;
        s = '0;
        if (!has_bad(x, y)) begin
            xv = 0; yv = 0; lim = 1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                xv  = xv * 10 + longint'(x[4*i +: 4]);
                yv  = yv * 10 + longint'(y[4*i +: 4]);
                lim = lim * 10;
            end
            t = xv + yv + longint'(ci);
            c = (t >= lim);
            t = t % lim;
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end else begin
            c = ci;
            for (int i = 0; i < DIGITS; i++) begin
                ds = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + int'(c);
                if (ds > 9) begin
                    s[4*i +: 4] = 4'((ds + 6) % 16);
                    c = 1'b1;
                end else begin
                    s[4*i +: 4] = 4'(ds);
                    c = 1'b0;
                end
            end
        end
        return {c, s};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Model: busy countdown after an accepted start; 1 marks the done cycle
    int           m_cnt = 0;
    logic [W:0]   m_res = '0;
    logic [W:0]   m_hold = '0;
    bit           m_res_err = 1'b0;
    bit           m_hold_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt      <= 0;
            m_hold     <= '0;
            m_hold_err <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_res     <= ref_add(a, b, cin);
                m_res_err <= has_bad(a, b);
                m_cnt     <= DIGITS + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_hold     <= m_res;
                m_hold_err <= m_res_err;
            end
        end
    end

    always @(negedge clk) begin
        check("ready", 64'(ready), 64'(m_cnt == 0));
        check("done", 64'(done), 64'(m_cnt == 1));
        if (m_cnt == 1) begin
            check("sum_at_done", 64'(sum), 64'(m_res[W-1:0]));
            check("cout_at_done", 64'(cout), 64'(m_res[W]));
`ifdef BCD_INPUT_CHECK_EN
            check("err_at_done", 64'(err), 64'(m_res_err));
`endif
        end else if (m_cnt == 0) begin
            check("sum_hold", 64'(sum), 64'(m_hold[W-1:0]));
            check("cout_hold", 64'(cout), 64'(m_hold[W]));
`ifdef BCD_INPUT_CHECK_EN
            check("err_hold", 64'(err), 64'(m_hold_err));
`endif
        end
    end

    task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input bit pester,
                          output logic [W-1:0] s, output logic co, output int lat);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 64'(n < 50), 64'd1);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 50) begin
            if (pester) begin
                start = 1'b1;
                a = 16'h1111;
                check("ready_busy", 64'(ready), 64'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("done_timeout", 64'(lat < 50), 64'd1);
        s  = sum;
        co = cout;
        if (pester) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", 64'(ready), 64'd1);
        end
    endtask

    logic [W-1:0] r_sum;
    logic         r_cout;
    int           r_lat;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        #11 rst_n = 1'b1;

        check("model_1234_5678", 64'(ref_add(16'h1234, 16'h5678, 1'b0)), 64'h0_6912);
        check("model_9999_0001", 64'(ref_add(16'h9999, 16'h0001, 1'b0)), 64'h1_0000);
        check("model_9999_9999_c", 64'(ref_add(16'h9999, 16'h9999, 1'b1)), 64'h1_9999);
        check("model_00A0", 64'(ref_add(16'h00A0, 16'h0000, 1'b0)), 64'h0_0100);

        do_add(16'h1234, 16'h5678, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        check("sum_6912", 64'(r_sum), 64'h6912);
        check("cout_6912", 64'(r_cout), 64'd0);
        check("latency", 64'(r_lat), 64'd5);

        do_add(16'h9999, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        check("sum_ripple", 64'(r_sum), 64'h0000);
        check("cout_ripple", 64'(r_cout), 64'd1);

        do_add(16'h9999, 16'h9999, 1'b1, 1'b0, r_sum, r_cout, r_lat);
        check("sum_max", 64'(r_sum), 64'h9999);
        check("cout_max", 64'(r_cout), 64'd1);

        do_add(16'h2468, 16'h1357, 1'b0, 1'b1, r_sum, r_cout, r_lat);
        check("sum_restart_ignored", 64'(r_sum), 64'h3825);
        check("cout_restart_ignored", 64'(r_cout), 64'd0);

`ifdef BCD_INPUT_CHECK_EN
        do_add(16'h00A0, 16'h0000, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        check("err_set", 64'(err), 64'd1);
        do_add(16'h0001, 16'h0002, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        check("err_cleared", 64'(err), 64'd0);
        check("sum_after_err", 64'(r_sum), 64'h0003);
`endif

        // Abort in the second ADD cycle
        @(posedge clk); #1;
        a = 16'h4321; b = 16'h5555; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(done), 64'd0);
        end

        do_add(16'h0505, 16'h0505, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        check("sum_after_abort", 64'(r_sum), 64'h1010);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a     = rand_bcd();
            b     = rand_bcd();
            cin   = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (DIGITS + 4) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
